// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline control slice: hazard field codes,
// hazard vector bit positions, tracker states and counter selects.
package pipe_pkg;

  localparam logic [1:0] HZ_RUN   = 2'b00;
  localparam logic [1:0] HZ_STALL = 2'b01;
  localparam logic [1:0] HZ_ILL   = 2'b10;
  localparam logic [1:0] HZ_FLUSH = 2'b11;

  // hazard vector layout: {PC, IF_ID[1:0], ID_EX[1:0], EX_MEM[1:0], MEM_WB}
  localparam int unsigned HZ_PC_BIT     = 7;
  localparam int unsigned HZ_IF_ID_LSB  = 5;
  localparam int unsigned HZ_ID_EX_LSB  = 3;
  localparam int unsigned HZ_EX_MEM_LSB = 1;
  localparam int unsigned HZ_MEM_WB_BIT = 0;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH,
    FREEZE
  } pipe_state_e;

  localparam logic [1:0] CNT_SEL_CYCLES = 2'd0;
  localparam logic [1:0] CNT_SEL_STALL  = 2'd1;
  localparam logic [1:0] CNT_SEL_FLUSH  = 2'd2;
  localparam logic [1:0] CNT_SEL_FREEZE = 2'd3;

endpackage

// File: rtl/hz_field_dec.sv
// Decodes one 2-bit hazard field into raw register enable / bubble strobes.
// Illegal code behaves as a stall and is reported separately.
module hz_field_dec
  import pipe_pkg::*;
(
  input  logic [1:0] field,
  output logic       en,
  output logic       flush,
  output logic       ill
);

  always_comb begin
    en    = 1'b0;
    flush = 1'b0;
    ill   = 1'b0;
    unique case (field)
      HZ_RUN:   en = 1'b1;
      HZ_STALL: ;
      HZ_FLUSH: begin
        en    = 1'b1;
        flush = 1'b1;
      end
      HZ_ILL:   ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline register control: decodes the hazard vector into stage strobes,
// tracks RUN/STALL/FLUSH/FREEZE, and keeps perf counters plus a stall watchdog.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       hazard_i,
  input  logic             ext_stall_i,
  input  logic [1:0]       cnt_sel_i,
  input  logic             cnt_clr_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic [CNT_W-1:0] cnt_rdata_o,
  output logic             stall_timeout_o,
  output logic             illegal_code_o
);

  localparam int unsigned     SR_W   = $clog2(MAX_STALL + 1);
  localparam logic [SR_W-1:0] SR_MAX = SR_W'(MAX_STALL);

  logic [2:0]       f_en;
  logic [2:0]       f_flush;
  logic [2:0]       f_ill;
  logic             gate;
  logic             any_stall;
  logic             any_flush;
  logic             flush_strobe;
  logic [3:0]       inc;
  pipe_state_e      state;
  pipe_state_e      nxt;
  logic [SR_W-1:0]  stall_run;
  logic [CNT_W-1:0] cnt [4];

  hz_field_dec u_if_id (
    .field (hazard_i[HZ_IF_ID_LSB +: 2]),
    .en    (f_en[2]),
    .flush (f_flush[2]),
    .ill   (f_ill[2])
  );

  hz_field_dec u_id_ex (
    .field (hazard_i[HZ_ID_EX_LSB +: 2]),
    .en    (f_en[1]),
    .flush (f_flush[1]),
    .ill   (f_ill[1])
  );

  hz_field_dec u_ex_mem (
    .field (hazard_i[HZ_EX_MEM_LSB +: 2]),
    .en    (f_en[0]),
    .flush (f_flush[0]),
    .ill   (f_ill[0])
  );

  // Freeze and reset both silence every strobe; a dropped flush is re-issued upstream.
  always_comb begin
    gate           = rst_i | ext_stall_i;
    pc_en_o        = ~gate & ~hazard_i[HZ_PC_BIT];
    if_id_en_o     = ~gate & f_en[2];
    id_ex_en_o     = ~gate & f_en[1];
    ex_mem_en_o    = ~gate & f_en[0];
    mem_wb_en_o    = ~gate;
    if_id_flush_o  = ~gate & f_flush[2];
    id_ex_flush_o  = ~gate & f_flush[1];
    ex_mem_flush_o = ~gate & f_flush[0];
    mem_wb_flush_o = ~gate & hazard_i[HZ_MEM_WB_BIT];
    flush_strobe   = if_id_flush_o | id_ex_flush_o | ex_mem_flush_o | mem_wb_flush_o;

    // a field that is not enabled is holding (stall or illegal code)
    any_stall = hazard_i[HZ_PC_BIT] | ~&f_en;
    any_flush = |f_flush | hazard_i[HZ_MEM_WB_BIT];

    nxt = RUN;
    if (ext_stall_i)                 nxt = FREEZE;
    else if (any_flush && !any_stall) nxt = FLUSH;
    else if (any_stall)              nxt = STALL;

    inc                 = '0;
    inc[CNT_SEL_CYCLES] = 1'b1;
    inc[CNT_SEL_STALL]  = (nxt == STALL);
    inc[CNT_SEL_FLUSH]  = flush_strobe;
    inc[CNT_SEL_FREEZE] = (nxt == FREEZE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= RUN;
      stall_run       <= '0;
      stall_timeout_o <= 1'b0;
      illegal_code_o  <= 1'b0;
    end else begin
      state <= nxt;
      if (cnt_clr_i) begin
        stall_run       <= '0;
        stall_timeout_o <= 1'b0;
        illegal_code_o  <= 1'b0;
      end else begin
        if (|f_ill) illegal_code_o <= 1'b1;
        // freeze cycles pause the stall run rather than breaking it
        if (nxt == STALL) begin
          if (stall_run != SR_MAX) stall_run <= stall_run + SR_W'(1);
          if (stall_run >= SR_MAX - SR_W'(1)) stall_timeout_o <= 1'b1;
        end else if (nxt != FREEZE) begin
          stall_run <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
      cnt_rdata_o <= '0;
    end else begin
      cnt_rdata_o <= cnt[cnt_sel_i];
      for (int unsigned i = 0; i < 4; i++) begin
        if (cnt_clr_i)                    cnt[i] <= '0;
        else if (inc[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // a stall run can only be non-zero while stalled or frozen
  assert property (@(posedge clk_i) disable iff (rst_i)
    (state inside {RUN, FLUSH}) |-> (stall_run == '0));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model expectations per cycle,
// monitor pops and compares strobes and registered outputs after each edge.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W     = 6;
  localparam int unsigned MAX_STALL = 8;
  localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;
  localparam int K_RUN = 0, K_STALL = 1, K_FLUSH = 2, K_FREEZE = 3;

  typedef struct packed {
    logic [4:0]       en;
    logic [3:0]       fl;
    logic [CNT_W-1:0] rd;
    logic             to;
    logic             il;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [7:0]       hazard_i = '0;
  logic             ext_stall_i = 1'b0;
  logic [1:0]       cnt_sel_i = '0;
  logic             cnt_clr_i = 1'b0;
  logic             pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic             if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o;
  logic [CNT_W-1:0] cnt_rdata_o;
  logic             stall_timeout_o, illegal_code_o;

  exp_t        q[$];
  int unsigned m_cnt[4];
  int unsigned m_run;
  bit          m_to, m_il;
  int          n_vec = 0;
  int          n_err = 0;

  pipe_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .hazard_i        (hazard_i),
    .ext_stall_i     (ext_stall_i),
    .cnt_sel_i       (cnt_sel_i),
    .cnt_clr_i       (cnt_clr_i),
    .pc_en_o         (pc_en_o),
    .if_id_en_o      (if_id_en_o),
    .id_ex_en_o      (id_ex_en_o),
    .ex_mem_en_o     (ex_mem_en_o),
    .mem_wb_en_o     (mem_wb_en_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .ex_mem_flush_o  (ex_mem_flush_o),
    .mem_wb_flush_o  (mem_wb_flush_o),
    .cnt_rdata_o     (cnt_rdata_o),
    .stall_timeout_o (stall_timeout_o),
    .illegal_code_o  (illegal_code_o)
  );

  always #5 clk = ~clk;

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Apply one cycle of stimulus and push what the DUT must show for it.
  task automatic drive(input bit r, input logic [7:0] h, input bit x,
                       input logic [1:0] s, input bit c);
    exp_t       e;
    int         n_stall, n_flush, kind;
    bit         bad;
    logic [1:0] code;
    @(negedge clk);
    rst_i = r; hazard_i = h; ext_stall_i = x; cnt_sel_i = s; cnt_clr_i = c;
    n_stall = int'(h[7]);
    n_flush = int'(h[0]);
    bad     = 1'b0;
    e       = '0;
    for (int k = 0; k < 3; k++) begin
      code = 2'(h >> (5 - 2 * k));
      if (code == 2'b01 || code == 2'b10) n_stall++;
      if (code == 2'b11) n_flush++;
      if (code == 2'b10) bad = 1'b1;
      if (!r && !x) begin
        e.en[3-k] = (code == 2'b00 || code == 2'b11);
        e.fl[3-k] = (code == 2'b11);
      end
    end
    if (!r && !x) begin
      e.en[4] = !h[7];
      e.en[0] = 1'b1;
      e.fl[0] = h[0];
    end
    if (x)                             kind = K_FREEZE;
    else if (n_flush > 0 && n_stall == 0) kind = K_FLUSH;
    else if (n_stall > 0)              kind = K_STALL;
    else                               kind = K_RUN;

    e.rd = r ? '0 : CNT_W'(m_cnt[s]);
    if (r || c) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_run = 0; m_to = 1'b0; m_il = 1'b0;
    end else begin
      m_cnt[0] = sat_inc(m_cnt[0]);
      if (kind == K_STALL) m_cnt[1] = sat_inc(m_cnt[1]);
      if (|e.fl)           m_cnt[2] = sat_inc(m_cnt[2]);
      if (kind == K_FREEZE) m_cnt[3] = sat_inc(m_cnt[3]);
      if (kind == K_STALL) begin
        if (m_run < MAX_STALL) m_run++;
        if (m_run >= MAX_STALL) m_to = 1'b1;
      end else if (kind != K_FREEZE) begin
        m_run = 0;
      end
      if (bad) m_il = 1'b1;
    end
    e.to = m_to;
    e.il = m_il;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_vec++;
        check("en", 32'({pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o}), 32'(e.en));
        check("flush", 32'({if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o}), 32'(e.fl));
        check("cnt_rdata", 32'(cnt_rdata_o), 32'(e.rd));
        check("stall_timeout", 32'(stall_timeout_o), 32'(e.to));
        check("illegal_code", 32'(illegal_code_o), 32'(e.il));
      end
    end
  end

  function automatic logic [7:0] rand_hz();
    logic [7:0] h;
    logic [1:0] legal [3];
    legal[0] = 2'b00; legal[1] = 2'b01; legal[2] = 2'b11;
    h[7] = ($urandom_range(0, 3) == 0);
    h[0] = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < 3; k++) begin
      h[6-2*k -: 2] = ($urandom_range(0, 19) == 0) ? 2'b10 : legal[$urandom_range(0, 2)];
    end
    return h;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL sim_timeout: got no finish, expected finish before 500000");
    $fatal(1);
  end

  initial begin : stimulus
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_run = 0; m_to = 1'b0; m_il = 1'b0;

    for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom), 1'($urandom), 2'd0, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);

    drive(1'b0, 8'b0_11_11_00_0, 1'b0, 2'd2, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 2'd2, 1'b0);

    drive(1'b0, 8'b1_01_11_00_0, 1'b0, 2'd1, 1'b0);
    drive(1'b0, 8'b1_01_01_11_0, 1'b0, 2'd1, 1'b0);
    drive(1'b0, 8'b1_01_01_01_1, 1'b0, 2'd1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 2'd1, 1'b0);

    for (int i = 0; i < MAX_STALL; i++) drive(1'b0, 8'b1_01_11_00_0, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 2'd1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 2'd1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 2'd1, 1'b0);

    drive(1'b0, 8'b0_11_11_00_0, 1'b1, 2'd2, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 2'd3, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 2'd2, 1'b0);

    // freeze inside a stall run must not break it: 5 + freeze + 3 reaches the limit
    for (int i = 0; i < 5; i++) drive(1'b0, 8'b1_01_00_00_0, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'b1_01_00_00_0, 1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, 8'b1_01_00_00_0, 1'b0, 2'd1, 1'b0);
    drive(1'b0, 8'b1_01_00_00_0, 1'b0, 2'd1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 2'd1, 1'b1);

    drive(1'b0, 8'b0_10_00_00_0, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < 3; i++) drive(1'b0, 8'b1_01_01_00_0, 1'b0, 2'd1, 1'b0);
    drive(1'b1, 8'b1_01_01_00_0, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0, 2'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b1, 2'd3, 1'b0);
    drive(1'b1, 8'h00, 1'b1, 2'd3, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 2'd3, 1'b0);

    // saturation of the cycle counter
    drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < CNT_MAX + 6; i++) drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 99) == 0), rand_hz(), ($urandom_range(0, 7) == 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 49) == 0));

    drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
